key_expansion_seq: RTL and testbench



---
 rtl/key_expansion_seq_if.sv | 11 +
 rtl/key_expansion_seq.sv | 113 +++++++++++
 tb/tb_key_expansion_seq.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/key_expansion_seq_if.sv
// Handshake and expanded-key bus between the key schedule and its consumer.
interface key_expansion_seq_if;
  logic          start;
  logic [127:0]  key_in;
  logic          busy;
  logic          valid;
  logic [1407:0] w;

  modport master (output start, key_in, input busy, valid, w);
  modport slave  (input start, key_in, output busy, valid, w);
endinterface

// File: rtl/key_expansion_seq.sv
// Sequential AES-128 key schedule: one round key per clock, 10 cycles from
// start to a stable 1408-bit expanded key with valid asserted.
module key_expansion_seq #(
  parameter int unsigned NR = 10
) (
  input logic clk,
  input logic rst,
  key_expansion_seq_if.slave bus
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bits [2047-8x -: 8]; 2047-8x is just {~x, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    sbox = SBOX[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t        state;
  logic [3:0]    round;
  logic [7:0]    rcon;
  logic [127:0]  cur;
  logic [127:0]  rk [NR+1];
  logic          busy_q;
  logic          valid_q;

  logic [31:0]   rot;
  logic [31:0]   temp;
  logic [31:0]   q0, q1, q2, q3;
  logic [127:0]  nxt;
  logic [1407:0] wbus;

  // cur mirrors the most recently written slot so the round function needs no slot mux.
  always_comb begin
    rot  = {cur[23:0], cur[31:24]};
    temp = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    q0   = cur[127:96] ^ temp;
    q1   = cur[95:64]  ^ q0;
    q2   = cur[63:32]  ^ q1;
    q3   = cur[31:0]   ^ q2;
    nxt  = {q0, q1, q2, q3};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      round   <= '0;
      rcon    <= 8'h01;
      cur     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int unsigned i = 0; i <= NR; i++) rk[i] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            rk[0]   <= bus.key_in;
            cur     <= bus.key_in;
            round   <= 4'd1;
            rcon    <= 8'h01;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
            state   <= EXPAND;
          end
        end
        EXPAND: begin
          rk[round] <= nxt;
          cur       <= nxt;
          round     <= round + 4'd1;
          rcon      <= xtime(rcon);
          if (round == NR[3:0]) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    wbus = '0;
    for (int unsigned i = 0; i <= NR; i++) wbus[1407 - i*128 -: 128] = rk[i];
  end

  assign bus.w     = wbus;
  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_key_expansion_seq.sv
// Scoreboard bench for key_expansion_seq: the driver queues expected schedules,
// the monitor checks them (and their timing) whenever valid rises.
module tb_key_expansion_seq;

  logic clk = 1'b0;
  logic rst;
  key_expansion_seq_if bus();

  key_expansion_seq #(.NR(10)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_Z   = 128'h0;
  localparam logic [127:0] Z_R1    = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_R10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  typedef struct {
    logic [127:0] r0;
    logic [127:0] r1;
    logic [127:0] r10;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] slot(input logic [1407:0] w, input int r);
    slot = w[1407 - r*128 -: 128];
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: on each valid rise, pop and compare schedule, arrival cycle and busy length.
  logic prev_valid = 1'b0;
  int   bcnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (bus.valid && !prev_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid at cycle %0d (no pending expectation)", cyc);
      end else begin
        e = sb.pop_front();
        chk("slot0", slot(bus.w, 0), e.r0);
        chk("slot1", slot(bus.w, 1), e.r1);
        chk("slot10", slot(bus.w, 10), e.r10);
        chk("valid_cycle", 128'(cyc), 128'(e.cyc));
        chk("busy_len", 128'(bcnt), 128'd10);
      end
    end
    prev_valid = bus.valid;
    if (bus.busy) bcnt++;
    else bcnt = 0;
  end

  task automatic start_key(input logic [127:0] key, input logic [127:0] r1,
                           input logic [127:0] r10, input bit expect_it);
    exp_t e;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.key_in = key;
    @(posedge clk);
    #1;
    if (expect_it) begin
      e.r0 = key; e.r1 = r1; e.r10 = r10; e.cyc = cyc + 10;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout pending=%0d required=0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.key_in = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 128'(bus.busy), 128'd0);
    chk("rst_valid", 128'(bus.valid), 128'd0);
    chk("rst_w_hi", bus.w[1407:1280], 128'd0);
    chk("rst_w_lo", bus.w[127:0], 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // FIPS-197 A.1
    start_key(KEY_A1, A1_R1, A1_R10, 1'b1);
    wait_drain("a1");

    // Restart from DONE with the zero key: valid must drop on the accepting edge.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.key_in = KEY_Z;
    @(posedge clk);
    #1;
    sb.push_back('{r0: KEY_Z, r1: Z_R1, r10: Z_R10, cyc: cyc + 10});
    chk("restart_valid", 128'(bus.valid), 128'd0);
    chk("restart_busy", 128'(bus.busy), 128'd1);
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain("zero");

    // start re-asserted mid-expansion with all-ones key must be ignored.
    start_key(KEY_A1, A1_R1, A1_R10, 1'b1);
    repeat (2) @(negedge clk);
    bus.start  = 1'b1;
    bus.key_in = '1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain("ignored_start");

    // Reset in the middle of an expansion abandons it.
    start_key(KEY_Z, Z_R1, Z_R10, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", 128'(bus.busy), 128'd0);
    chk("midrst_valid", 128'(bus.valid), 128'd0);
    chk("midrst_w_hi", bus.w[1407:1280], 128'd0);
    chk("midrst_w_r1", bus.w[1279:1152], 128'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("midrst_no_valid", 128'(bus.valid), 128'd0);
    start_key(KEY_A1, A1_R1, A1_R10, 1'b1);
    wait_drain("after_rst");

    // Hold in DONE with start low and key_in churning.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      bus.key_in = {$urandom, $urandom, $urandom, $urandom};
      #1;
      chk("hold_valid", 128'(bus.valid), 128'd1);
      chk("hold_r0", slot(bus.w, 0), KEY_A1);
      chk("hold_r10", slot(bus.w, 10), A1_R10);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
